// File: rtl/async_fifo_level_if.sv
// Bus bundle for async_fifo_level.
// Write side: write, write_data in; can_write, write_level, almost_full, overflow out.
// Read side: read in; read_data, read_valid, can_read, read_level, almost_empty, underflow out.
// master = the client that pushes and pops, slave = the FIFO itself.
interface async_fifo_level_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  write;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  can_write;
  logic [ADDR_WIDTH:0]   write_level;
  logic                  almost_full;
  logic                  overflow;
  logic                  read;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  can_read;
  logic [ADDR_WIDTH:0]   read_level;
  logic                  almost_empty;
  logic                  underflow;

  modport master (
    output write, write_data, read,
    input  can_write, write_level, almost_full, overflow,
    input  read_data, read_valid, can_read, read_level, almost_empty, underflow
  );

  modport slave (
    input  write, write_data, read,
    output can_write, write_level, almost_full, overflow,
    output read_data, read_valid, can_read, read_level, almost_empty, underflow
  );
endinterface

// File: rtl/async_fifo_level.sv
// Dual-clock FIFO with fill levels in both domains, programmable almost
// flags, show-ahead or registered read, and sticky overflow/underflow flags.
// Ports:
//   reset     - asynchronous active-high reset, synchronised into each domain
//   write_clk - write-domain clock
//   read_clk  - read-domain clock
//   fifoBus   - slave side of async_fifo_level_if (push/pop handshake, levels, flags)
module async_fifo_level #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH   = 4,
  parameter int FWFT        = 1
) (
  input logic reset,
  input logic write_clk,
  input logic read_clk,
  async_fifo_level_if.slave fifoBus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t AF_LEVEL    = ptr_t'(AF_THRESH);
  localparam ptr_t AE_LEVEL    = ptr_t'(AE_THRESH);
  localparam logic AF_AT_RESET = (AF_THRESH == 0);

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Reset synchronisers: assert immediately, release on the local clock so
  // each domain leaves reset cleanly.
  logic [1:0] wrRstSync_q;
  logic [1:0] rdRstSync_q;
  logic       wrRst;
  logic       rdRst;

  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) wrRstSync_q <= 2'b11;
    else       wrRstSync_q <= {wrRstSync_q[0], 1'b0};
  end

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) rdRstSync_q <= 2'b11;
    else       rdRstSync_q <= {rdRstSync_q[0], 1'b0};
  end

  assign wrRst = wrRstSync_q[1];
  assign rdRst = rdRstSync_q[1];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write-domain state
  ptr_t wrPtrBin_q, wrPtrBin_d, wrPtrGray_q, wrPtrGray_d;
  ptr_t rdGraySync_q [SYNC_STAGES];
  ptr_t rdSyncGray, rdSyncBin, fullGray;
  ptr_t writeLevel_q, writeLevel_d;
  logic canWrite_q, canWrite_d, almostFull_q, almostFull_d, overflow_q, overflow_d;
  logic push;

  // Read-domain state
  ptr_t rdPtrBin_q, rdPtrBin_d, rdPtrGray_q, rdPtrGray_d;
  ptr_t wrGraySync_q [SYNC_STAGES];
  ptr_t wrSyncGray, wrSyncBin;
  ptr_t readLevel_q, readLevel_d;
  logic canRead_q, canRead_d, almostEmpty_q, almostEmpty_d, underflow_q, underflow_d;
  logic readValid_q, readValid_d;
  logic [DATA_WIDTH-1:0] readData_q, readData_d;
  logic pop;

  // Write side next state. Full means the next write pointer has lapped the
  // synced read pointer by exactly one depth, which in gray code is the read
  // pointer with its two top bits inverted.
  always_comb begin
    push         = fifoBus.write && canWrite_q && !wrRst;
    wrPtrBin_d   = wrPtrBin_q + ptr_t'(push);
    wrPtrGray_d  = bin2gray(wrPtrBin_d);
    rdSyncGray   = rdGraySync_q[SYNC_STAGES-1];
    rdSyncBin    = gray2bin(rdSyncGray);
    fullGray     = {~rdSyncGray[PW-1:PW-2], rdSyncGray[PW-3:0]};
    canWrite_d   = (wrPtrGray_d != fullGray);
    writeLevel_d = wrPtrBin_d - rdSyncBin;
    almostFull_d = (writeLevel_d >= AF_LEVEL);
    overflow_d   = overflow_q | (fifoBus.write & ~canWrite_q);
  end

  // Write-domain registers, including the read-pointer synchroniser.
  always_ff @(posedge write_clk or posedge wrRst) begin
    if (wrRst) begin
      wrPtrBin_q   <= '0;
      wrPtrGray_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rdGraySync_q[i] <= '0;
      canWrite_q   <= 1'b1;
      writeLevel_q <= '0;
      almostFull_q <= AF_AT_RESET;
      overflow_q   <= 1'b0;
    end else begin
      wrPtrBin_q      <= wrPtrBin_d;
      wrPtrGray_q     <= wrPtrGray_d;
      rdGraySync_q[0] <= rdPtrGray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rdGraySync_q[i] <= rdGraySync_q[i-1];
      canWrite_q   <= canWrite_d;
      writeLevel_q <= writeLevel_d;
      almostFull_q <= almostFull_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge write_clk) begin
    if (push) mem[wrPtrBin_q[ADDR_WIDTH-1:0]] <= fifoBus.write_data;
  end

  // Read side next state. In show-ahead mode the output register is loaded
  // from the post-pop address so the new head is visible right after a pop.
  always_comb begin
    pop           = fifoBus.read && canRead_q;
    rdPtrBin_d    = rdPtrBin_q + ptr_t'(pop);
    rdPtrGray_d   = bin2gray(rdPtrBin_d);
    wrSyncGray    = wrGraySync_q[SYNC_STAGES-1];
    wrSyncBin     = gray2bin(wrSyncGray);
    canRead_d     = (rdPtrGray_d != wrSyncGray);
    readLevel_d   = wrSyncBin - rdPtrBin_d;
    almostEmpty_d = (readLevel_d <= AE_LEVEL);
    underflow_d   = underflow_q | (fifoBus.read & ~canRead_q);
    if (FWFT != 0) begin
      readData_d  = canRead_d ? mem[rdPtrBin_d[ADDR_WIDTH-1:0]] : '0;
      readValid_d = 1'b0;
    end else begin
      readData_d  = pop ? mem[rdPtrBin_q[ADDR_WIDTH-1:0]] : readData_q;
      readValid_d = pop;
    end
  end

  // Read-domain registers, including the write-pointer synchroniser.
  always_ff @(posedge read_clk or posedge rdRst) begin
    if (rdRst) begin
      rdPtrBin_q    <= '0;
      rdPtrGray_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wrGraySync_q[i] <= '0;
      canRead_q     <= 1'b0;
      readLevel_q   <= '0;
      almostEmpty_q <= 1'b1;
      underflow_q   <= 1'b0;
      readValid_q   <= 1'b0;
      readData_q    <= '0;
    end else begin
      rdPtrBin_q      <= rdPtrBin_d;
      rdPtrGray_q     <= rdPtrGray_d;
      wrGraySync_q[0] <= wrPtrGray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wrGraySync_q[i] <= wrGraySync_q[i-1];
      canRead_q     <= canRead_d;
      readLevel_q   <= readLevel_d;
      almostEmpty_q <= almostEmpty_d;
      underflow_q   <= underflow_d;
      readValid_q   <= readValid_d;
      readData_q    <= readData_d;
    end
  end

  assign fifoBus.can_write    = canWrite_q;
  assign fifoBus.write_level  = writeLevel_q;
  assign fifoBus.almost_full  = almostFull_q;
  assign fifoBus.overflow     = overflow_q;
  assign fifoBus.can_read     = canRead_q;
  assign fifoBus.read_level   = readLevel_q;
  assign fifoBus.almost_empty = almostEmpty_q;
  assign fifoBus.underflow    = underflow_q;
  assign fifoBus.read_data    = readData_q;
  assign fifoBus.read_valid   = (FWFT != 0) ? canRead_q : readValid_q;
endmodule

// File: tb/tb_async_fifo_level.sv
// Testbench for async_fifo_level: a 16-deep show-ahead instance checked every
// cycle against a queue model, plus a registered-read instance for directed
// read_valid checks.
module tb_async_fifo_level;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic reset = 1'b1;
  logic write_clk = 1'b0;
  logic read_clk = 1'b0;
  int   wrHalf = 10;
  int   rdHalf = 15;

  int   checks = 0;
  int   errors = 0;
  bit   monEn = 0;
  logic [DW-1:0] modelQ[$];
  logic expOverflow = 1'b0;
  logic expUnderflow = 1'b0;
  logic [DW-1:0] f0Data [3];

  async_fifo_level_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifoBus ();
  async_fifo_level_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifoBus0 ();

  async_fifo_level #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
                     .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_dut (
    .reset(reset), .write_clk(write_clk), .read_clk(read_clk), .fifoBus(fifoBus));

  async_fifo_level #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
                     .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_dut0 (
    .reset(reset), .write_clk(write_clk), .read_clk(read_clk), .fifoBus(fifoBus0));

  initial forever #(wrHalf) write_clk = ~write_clk;
  initial forever #(rdHalf) read_clk = ~read_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of accepted entries plus the sticky error flags.
  always @(posedge write_clk) begin
    if (!reset) begin
      if (fifoBus.write && fifoBus.can_write) modelQ.push_back(fifoBus.write_data);
      if (fifoBus.write && !fifoBus.can_write) expOverflow = 1'b1;
    end
  end

  always @(posedge read_clk) begin
    if (!reset) begin
      if (fifoBus.read && fifoBus.can_read) void'(modelQ.pop_front());
      if (fifoBus.read && !fifoBus.can_read) expUnderflow = 1'b1;
    end
  end

  // Write-domain compare: the writer's level may overstate the true fill but never understate it.
  always @(negedge write_clk) begin
    if (monEn) begin
      checkOutput("wlevel_ge_occupancy", 32'(fifoBus.write_level >= modelQ.size()), 1);
      checkOutput("wlevel_le_depth", 32'(fifoBus.write_level <= DEPTH), 1);
      checkOutput("can_write_vs_level", 32'(fifoBus.can_write), 32'(fifoBus.write_level < DEPTH));
      checkOutput("almost_full_vs_level", 32'(fifoBus.almost_full), 32'(fifoBus.write_level >= AF));
      checkOutput("overflow_flag", 32'(fifoBus.overflow), 32'(expOverflow));
    end
  end

  // Read-domain compare: head data must match the model; the reader's level may only understate.
  always @(negedge read_clk) begin
    if (monEn) begin
      checkOutput("can_read_implies_data", 32'(!fifoBus.can_read || modelQ.size() > 0), 1);
      if (fifoBus.can_read && modelQ.size() > 0)
        checkOutput("read_data_head", 32'(fifoBus.read_data), 32'(modelQ[0]));
      else if (!fifoBus.can_read)
        checkOutput("read_data_zero", 32'(fifoBus.read_data), 0);
      checkOutput("rlevel_le_occupancy", 32'(fifoBus.read_level <= modelQ.size()), 1);
      checkOutput("can_read_vs_level", 32'(fifoBus.can_read), 32'(fifoBus.read_level != 0));
      checkOutput("almost_empty_vs_level", 32'(fifoBus.almost_empty), 32'(fifoBus.read_level <= AE));
      checkOutput("read_valid_fwft", 32'(fifoBus.read_valid), 32'(fifoBus.can_read));
      checkOutput("underflow_flag", 32'(fifoBus.underflow), 32'(expUnderflow));
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] value);
    @(negedge write_clk);
    fifoBus.write = 1'b1;
    fifoBus.write_data = value;
    @(negedge write_clk);
    fifoBus.write = 1'b0;
  endtask

  task automatic popOne(output logic [DW-1:0] got);
    int n = 0;
    @(negedge read_clk);
    while (!fifoBus.can_read && n < 20) begin
      @(negedge read_clk);
      n++;
    end
    checkOutput("pop_wait_can_read", 32'(fifoBus.can_read), 1);
    got = fifoBus.read_data;
    fifoBus.read = 1'b1;
    @(negedge read_clk);
    fifoBus.read = 1'b0;
  endtask

  task automatic waitReadLevel(input int lvl);
    int n = 0;
    while (fifoBus.read_level != lvl && n < 20) begin
      @(negedge read_clk);
      n++;
    end
    checkOutput("read_level_settle", 32'(fifoBus.read_level), 32'(lvl));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_can_write"}, 32'(fifoBus.can_write), 1);
    checkOutput({tag, "_write_level"}, 32'(fifoBus.write_level), 0);
    checkOutput({tag, "_almost_full"}, 32'(fifoBus.almost_full), 0);
    checkOutput({tag, "_overflow"}, 32'(fifoBus.overflow), 0);
    checkOutput({tag, "_can_read"}, 32'(fifoBus.can_read), 0);
    checkOutput({tag, "_read_level"}, 32'(fifoBus.read_level), 0);
    checkOutput({tag, "_read_data"}, 32'(fifoBus.read_data), 0);
    checkOutput({tag, "_almost_empty"}, 32'(fifoBus.almost_empty), 1);
    checkOutput({tag, "_underflow"}, 32'(fifoBus.underflow), 0);
    checkOutput({tag, "_read_valid"}, 32'(fifoBus.read_valid), 0);
    checkOutput({tag, "_f0_read_valid"}, 32'(fifoBus0.read_valid), 0);
    checkOutput({tag, "_f0_read_data"}, 32'(fifoBus0.read_data), 0);
  endtask

  task automatic releaseReset();
    @(negedge write_clk);
    reset = 1'b0;
    repeat (4) @(negedge write_clk);
    repeat (4) @(negedge read_clk);
    monEn = 1;
  endtask

  task automatic assertReset();
    monEn = 0;
    @(negedge write_clk);
    reset = 1'b1;
    modelQ.delete();
    expOverflow = 1'b0;
    expUnderflow = 1'b0;
    repeat (2) @(negedge write_clk);
  endtask

  task automatic randomPhase(input int wh, input int rh, input int n);
    wrHalf = wh;
    rdHalf = rh;
    fork
      begin
        int sent = 0;
        int cyc = 0;
        while (sent < n && cyc < 60000) begin
          @(negedge write_clk);
          cyc++;
          if (fifoBus.can_write && $urandom_range(3) != 0) begin
            fifoBus.write = 1'b1;
            fifoBus.write_data = DW'($urandom);
            sent++;
          end else begin
            fifoBus.write = 1'b0;
          end
        end
        @(negedge write_clk);
        fifoBus.write = 1'b0;
        checkOutput("random_writes_done", 32'(sent), 32'(n));
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 60000) begin
          @(negedge read_clk);
          cyc++;
          if (fifoBus.can_read && $urandom_range(3) != 0) begin
            fifoBus.read = 1'b1;
            got++;
          end else begin
            fifoBus.read = 1'b0;
          end
        end
        @(negedge read_clk);
        fifoBus.read = 1'b0;
        checkOutput("random_reads_done", 32'(got), 32'(n));
      end
    join
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    int n;
    f0Data[0] = 16'h1111;
    f0Data[1] = 16'h2222;
    f0Data[2] = 16'h3333;
    fifoBus.write = 1'b0;
    fifoBus.write_data = '0;
    fifoBus.read = 1'b0;
    fifoBus0.write = 1'b0;
    fifoBus0.write_data = '0;
    fifoBus0.read = 1'b0;

    repeat (3) @(negedge write_clk);
    checkResetValues("reset");
    releaseReset();

    $display("[TB] fill to full, then overflow");
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(DW'(k));
      checkOutput("fill_write_level", 32'(fifoBus.write_level), 32'(k + 1));
      checkOutput("fill_almost_full", 32'(fifoBus.almost_full), 32'(k + 1 >= AF));
      checkOutput("fill_can_write", 32'(fifoBus.can_write), 32'(k + 1 < DEPTH));
    end
    applyStimulus(16'hDEAD);
    checkOutput("overflow_set", 32'(fifoBus.overflow), 1);
    checkOutput("full_write_level", 32'(fifoBus.write_level), 16);
    waitReadLevel(16);

    $display("[TB] drain, then underflow");
    for (int i = 0; i < DEPTH; i++) begin
      popOne(got);
      checkOutput("drain_data", 32'(got), 32'(i));
      checkOutput("drain_read_level", 32'(fifoBus.read_level), 32'(DEPTH - 1 - i));
      checkOutput("drain_almost_empty", 32'(fifoBus.almost_empty), 32'(DEPTH - 1 - i <= AE));
    end
    @(negedge read_clk);
    fifoBus.read = 1'b1;
    @(negedge read_clk);
    fifoBus.read = 1'b0;
    checkOutput("underflow_set", 32'(fifoBus.underflow), 1);
    checkOutput("underflow_level", 32'(fifoBus.read_level), 0);
    checkOutput("underflow_can_read", 32'(fifoBus.can_read), 0);

    $display("[TB] single write latency");
    @(negedge write_clk);
    fifoBus.write = 1'b1;
    fifoBus.write_data = 16'hA5A5;
    @(posedge write_clk);
    #1;
    fifoBus.write = 1'b0;
    n = 0;
    while (!fifoBus.can_read && n < 8) begin
      @(posedge read_clk);
      #1;
      n++;
    end
    checkOutput("latency_3_to_4", 32'(n >= 3 && n <= 4), 1);
    checkOutput("single_read_data", 32'(fifoBus.read_data), 32'h0000A5A5);
    checkOutput("single_read_level", 32'(fifoBus.read_level), 1);
    @(negedge read_clk);
    fifoBus.read = 1'b1;
    @(negedge read_clk);
    fifoBus.read = 1'b0;
    checkOutput("single_after_pop_can_read", 32'(fifoBus.can_read), 0);
    checkOutput("single_after_pop_data", 32'(fifoBus.read_data), 0);

    $display("[TB] registered-read instance");
    for (int i = 0; i < 3; i++) begin
      @(negedge write_clk);
      fifoBus0.write = 1'b1;
      fifoBus0.write_data = f0Data[i];
    end
    @(negedge write_clk);
    fifoBus0.write = 1'b0;
    n = 0;
    while (fifoBus0.read_level != 3 && n < 20) begin
      @(negedge read_clk);
      n++;
    end
    checkOutput("f0_read_level", 32'(fifoBus0.read_level), 3);
    checkOutput("f0_idle_valid", 32'(fifoBus0.read_valid), 0);
    @(negedge read_clk);
    fifoBus0.read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge read_clk);
      checkOutput("f0_read_valid", 32'(fifoBus0.read_valid), 1);
      checkOutput("f0_read_data", 32'(fifoBus0.read_data), 32'(f0Data[i]));
    end
    fifoBus0.read = 1'b0;
    @(negedge read_clk);
    checkOutput("f0_valid_low", 32'(fifoBus0.read_valid), 0);
    checkOutput("f0_data_hold", 32'(fifoBus0.read_data), 32'h00003333);
    checkOutput("f0_can_read", 32'(fifoBus0.can_read), 0);
    checkOutput("f0_underflow", 32'(fifoBus0.underflow), 0);

    $display("[TB] random traffic, write:read clock 1:3 then 3:1");
    assertReset();
    releaseReset();
    randomPhase(10, 30, 5000);
    randomPhase(30, 10, 5000);
    repeat (6) @(negedge read_clk);
    checkOutput("random_no_overflow", 32'(fifoBus.overflow), 0);
    checkOutput("random_no_underflow", 32'(fifoBus.underflow), 0);
    checkOutput("random_model_empty", 32'(modelQ.size()), 0);
    checkOutput("random_can_read", 32'(fifoBus.can_read), 0);
    wrHalf = 10;
    rdHalf = 15;

    $display("[TB] reset while half full");
    for (int k = 0; k < 8; k++) applyStimulus(DW'(16'h7000 + k));
    waitReadLevel(8);
    assertReset();
    checkResetValues("midreset");
    releaseReset();
    for (int k = 0; k < 3; k++) applyStimulus(DW'(16'hBEE0 + k));
    waitReadLevel(3);
    for (int k = 0; k < 3; k++) begin
      popOne(got);
      checkOutput("post_reset_data", 32'(got), 32'(16'hBEE0 + k));
    end
    repeat (2) @(negedge read_clk);
    checkOutput("post_reset_empty", 32'(fifoBus.can_read), 0);
    checkOutput("post_reset_level", 32'(fifoBus.read_level), 0);
    monEn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
